// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder stage per clock, LSB first, through a single carry flop.
// Optional signed-overflow output enabled by defining BIT_SERIAL_ADDER_OVF_EN.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             s_bit,
    output logic             s_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic s_next, c_next, last;

    assign s_next = a_q[0] ^ b_q[0] ^ carry_q;
    assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign last   = (cnt_q == LAST);

    // NOTE: state and datapath flops use non-blocking assignments so every
    // flop samples the pre-edge values of the others, like real hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
    end

    // NOTE: operand and accumulator registers are reset too; they are few
    // bits and a known value simplifies debugging after a mid-run reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_bit   <= 1'b0;
            s_valid <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            done    <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            s_valid <= 1'b0;
            done    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    s_bit   <= s_next;
                    s_valid <= 1'b1;
                    carry_q <= c_next;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    acc_q   <= {s_next, acc_q[WIDTH-1:1]};
                    cnt_q   <= cnt_q + CW'(1);
                    if (last) begin
                        sum  <= {s_next, acc_q[WIDTH-1:1]};
                        cout <= c_next;
                        done <= 1'b1;
`ifdef BIT_SERIAL_ADDER_OVF_EN
                        // carry_q here is the carry into the MSB stage
                        ovf  <= carry_q ^ c_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
